cfg_routing_mux: RTL and testbench

Bank of CHANNELS independent IN_COUNT:1 one-bit routing multiplexers whose select values are loaded serially over a configuration scan chain and applied atomically on commit. Building block of the programmable interconnect: each instance sits at a switch-box/connection-box site and chains to its neighbours through cfg_in/cfg_out. Generalises the fixed 10:1 one-bit mux with parametrised width and channel count, bitstream loading, atomic update and range checking.

---
 rtl/cfg_routing_mux_pkg.sv | 19 +
 rtl/cfg_routing_mux_if.sv | 25 ++
 rtl/cfg_routing_mux_mux.sv | 24 ++
 rtl/cfg_routing_mux.sv | 102 ++++++++++
 tb/tb_cfg_routing_mux.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cfg_routing_mux_pkg.sv
// Shared types and width helpers for the cfg_routing_mux configuration slice.
package cfg_routing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        READY = 2'd2
    } cfg_state_e;

    // A mux with two inputs still needs one select bit.
    function automatic int sel_width(input int in_count);
        return (in_count <= 2) ? 1 : $clog2(in_count);
    endfunction

    function automatic int cfg_bits(input int in_count, input int channels);
        return channels * sel_width(in_count);
    endfunction

endpackage

// File: rtl/cfg_routing_mux_if.sv
// Configuration-chain and routed-data bundle for one cfg_routing_mux site.
interface cfg_routing_mux_if #(
    parameter int IN_COUNT = 10,
    parameter int CHANNELS = 4
);
    logic                         cfg_en;
    logic                         cfg_in;
    logic                         cfg_out;
    logic                         cfg_commit;
    logic                         cfg_done;
    logic                         cfg_err;
    logic [CHANNELS*IN_COUNT-1:0] data_in;
    logic [CHANNELS-1:0]          data_out;
    logic [CHANNELS-1:0]          range_err;

    modport master (
        output cfg_en, cfg_in, cfg_commit, data_in,
        input  cfg_out, cfg_done, cfg_err, data_out, range_err
    );

    modport slave (
        input  cfg_en, cfg_in, cfg_commit, data_in,
        output cfg_out, cfg_done, cfg_err, data_out, range_err
    );
endinterface

// File: rtl/cfg_routing_mux_mux.sv
// One-bit IN_COUNT:1 multiplexer; selects at or beyond IN_COUNT drive 0 and flag range.
module mux_n_1bit
    import cfg_routing_pkg::*;
#(
    parameter int IN_COUNT = 10,
    parameter int SEL_W    = sel_width(IN_COUNT)
) (
    input  logic [IN_COUNT-1:0] i_in,
    input  logic [SEL_W-1:0]    i_sel,
    output logic                o_out,
    output logic                o_range_err
);

    always_comb begin
        // NOTE: default first, so an unmatched select yields 0 and no latch is inferred.
        o_out = 1'b0;
        for (int i = 0; i < IN_COUNT; i++) begin
            if (i_sel == SEL_W'(i)) o_out = i_in[i];
        end
    end

    assign o_range_err = (int'(i_sel) >= IN_COUNT);

endmodule

// File: rtl/cfg_routing_mux.sv
// Bank of scan-configured one-bit routing muxes with atomic commit.
// Define CFG_ROUTING_MUX_OUT_REG_EN to register data_out (one cycle of latency).
module cfg_routing_mux
    import cfg_routing_pkg::*;
#(
    parameter int IN_COUNT = 10,
    parameter int CHANNELS = 4
) (
    input logic              clk,
    input logic              rst_n,
    cfg_routing_mux_if.slave bus
);

    localparam int SEL_W    = sel_width(IN_COUNT);
    localparam int CFG_BITS = cfg_bits(IN_COUNT, CHANNELS);
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    cfg_state_e          r_state;
    cfg_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CFG_BITS-1:0] r_sr;
    logic [CFG_BITS-1:0] r_active_sel;
    logic                r_cfg_err;
    logic                w_cfg_err_nxt;
    logic                w_commit_ok;
    logic [CHANNELS-1:0] w_mux_out;
    logic [CHANNELS-1:0] w_range_err;

    // Counter and state move together; a commit+shift cycle restarts the count at 1.
    always_comb begin
        w_commit_ok   = bus.cfg_commit && (r_state == READY);
        w_cfg_err_nxt = bus.cfg_commit && (r_state != READY);
        w_cnt_nxt     = r_cnt;
        if (w_commit_ok) begin
            w_cnt_nxt = bus.cfg_en ? CNT_W'(1) : '0;
        end else if (bus.cfg_en && (r_cnt != CNT_FULL)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (w_cnt_nxt == '0) begin
            w_state_nxt = IDLE;
        end else if (w_cnt_nxt == CNT_FULL) begin
            w_state_nxt = READY;
        end else begin
            w_state_nxt = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_active_sel <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            if (bus.cfg_en) r_sr <= {bus.cfg_in, r_sr[CFG_BITS-1:1]};
            // NOTE: non-blocking, so a commit captures the chain as it was before this cycle's shift.
            if (w_commit_ok) r_active_sel <= r_sr;
        end
    end

    assign bus.cfg_out  = r_sr[0];
    assign bus.cfg_done = (r_state == READY);
    assign bus.cfg_err  = r_cfg_err;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        mux_n_1bit #(
            .IN_COUNT (IN_COUNT),
            .SEL_W    (SEL_W)
        ) u_mux (
            .i_in        (bus.data_in[c*IN_COUNT +: IN_COUNT]),
            .i_sel       (r_active_sel[c*SEL_W +: SEL_W]),
            .o_out       (w_mux_out[c]),
            .o_range_err (w_range_err[c])
        );
    end

    assign bus.range_err = w_range_err;

`ifdef CFG_ROUTING_MUX_OUT_REG_EN
    logic [CHANNELS-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_mux_out;
        end
    end

    assign bus.data_out = r_data_out;
`else
    assign bus.data_out = w_mux_out;
`endif

endmodule

// File: tb/tb_cfg_routing_mux.sv
// Self-checking bench for cfg_routing_mux: vector table plus hand-written chain sequences.
`timescale 1ns/1ps
module tb_cfg_routing_mux;

    localparam int IN_COUNT = 10;
    localparam int CHANNELS = 4;
    localparam int CFG_BITS = 16;
    localparam int DW       = IN_COUNT * CHANNELS;
`ifdef CFG_ROUTING_MUX_OUT_REG_EN
    localparam int OUT_LAT = 1;
`else
    localparam int OUT_LAT = 0;
`endif

    typedef struct {
        logic [15:0]   sel;
        logic [DW-1:0] din;
        logic [3:0]    exp_out;
        logic [3:0]    exp_rerr;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic [3:0] rerr;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    cfg_routing_mux_if #(.IN_COUNT(IN_COUNT), .CHANNELS(CHANNELS)) bus ();

    cfg_routing_mux #(.IN_COUNT(IN_COUNT), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic din, input logic commit);
        bus.cfg_en     = en;
        bus.cfg_in     = din;
        bus.cfg_commit = commit;
        tick();
        bus.cfg_en     = 1'b0;
        bus.cfg_in     = 1'b0;
        bus.cfg_commit = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive(1'b1, w[i], 1'b0);
    endtask

    // Commit that is expected to be accepted; result is checked once data_out can show it.
    task automatic commit_expect(input string name, input logic [3:0] out, input logic [3:0] rerr,
                                 input logic with_shift, input logic bit_in);
        exp_t e;
        e.out  = out;
        e.rerr = rerr;
        e.name = name;
        sbq.push_back(e);
        drive(with_shift, bit_in, 1'b1);
        repeat (OUT_LAT) tick();
        e = sbq.pop_front();
        check({e.name, "_data_out"}, bus.data_out, e.out);
        check({e.name, "_range_err"}, bus.range_err, e.rerr);
        check({e.name, "_no_err"}, bus.cfg_err, 1'b0);
    endtask

    function automatic logic [DW-1:0] pick(input int i0, input int i1, input int i2, input int i3);
        logic [DW-1:0] r;
        int idx[4];
        r   = '0;
        idx = '{i0, i1, i2, i3};
        for (int c = 0; c < CHANNELS; c++) begin
            if (idx[c] >= 0) r[c*IN_COUNT + idx[c]] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev;
        logic        exp_bit;

        vecs[0] = '{16'h0C00, {DW{1'b1}},             4'b1011, 4'b0100};
        vecs[1] = '{16'h0000, pick(-1, 0, -1, -1),    4'b0010, 4'b0000};
        vecs[2] = '{16'hFFFF, {DW{1'b1}},             4'b0000, 4'b1111};
        vecs[3] = '{16'h9999, pick(9, 9, 9, -1),      4'b0111, 4'b0000};
        vecs[4] = '{16'hA0A0, {DW{1'b1}},             4'b0101, 4'b1010};
        vecs[5] = '{16'h2468, ~pick(8, -1, -1, -1),   4'b1110, 4'b0000};
        vecs[6] = '{16'h9531, pick(1, 3, 5, 9),       4'b1111, 4'b0000};

        bus.cfg_en     = 1'b0;
        bus.cfg_in     = 1'b0;
        bus.cfg_commit = 1'b0;
        bus.data_in    = pick(0, 0, 0, 0);
        rst_n          = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("rst_data_out", bus.data_out, 4'b1111);
        check("rst_cfg_done", bus.cfg_done, 1'b0);
        check("rst_range_err", bus.range_err, 4'b0000);
        check("rst_cfg_out", bus.cfg_out, 1'b0);
        check("rst_cfg_err", bus.cfg_err, 1'b0);

        // Vector table: load, commit, compare; cfg_out is modelled from the previous word.
        prev = 16'h0000;
        for (int v = 0; v < 7; v++) begin
            bus.data_in = vecs[v].din;
            for (int k = 1; k <= CFG_BITS; k++) begin
                drive(1'b1, vecs[v].sel[k-1], 1'b0);
                exp_bit = (k < CFG_BITS) ? prev[k] : vecs[v].sel[0];
                check($sformatf("v%0d_cfg_out_%0d", v, k), bus.cfg_out, exp_bit);
                check($sformatf("v%0d_done_%0d", v, k), bus.cfg_done, (k == CFG_BITS));
            end
            commit_expect($sformatf("v%0d", v), vecs[v].exp_out, vecs[v].exp_rerr, 1'b0, 1'b0);
            check($sformatf("v%0d_done_after_commit", v), bus.cfg_done, 1'b0);
            prev = vecs[v].sel;
        end

        // Selected input toggle: zero latency, or one cycle with the output register.
        bus.data_in[1] = 1'b0;
        #1;
        check("toggle_now", bus.data_out[0], (OUT_LAT != 0));
        tick();
        check("toggle_next", bus.data_out[0], 1'b0);
        bus.data_in[1] = 1'b1;
        repeat (OUT_LAT) tick();
        #1;
        check("toggle_back", bus.data_out[0], 1'b1);

        // Early commit after 10 shifts is rejected and does not disturb selects or count.
        shift_word(16'h0000, 10);
        drive(1'b0, 1'b0, 1'b1);
        check("early_cfg_err", bus.cfg_err, 1'b1);
        check("early_data_out", bus.data_out, 4'b1111);
        check("early_done", bus.cfg_done, 1'b0);
        tick();
        check("early_err_pulse", bus.cfg_err, 1'b0);
        shift_word(16'h0000, 5);
        check("early_done_15", bus.cfg_done, 1'b0);
        shift_word(16'h0000, 1);
        check("early_done_16", bus.cfg_done, 1'b1);
        commit_expect("early_final", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Commit with a same-cycle shift: old chain is committed and the count restarts at 1.
        shift_word(16'h9531, CFG_BITS);
        commit_expect("cshift", 4'b1111, 4'b0000, 1'b1, 1'b0);
        bus.data_in = ~pick(8, -1, -1, -1);
        shift_word(16'h1234, 14);
        check("cshift_done_15", bus.cfg_done, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("cshift_done_16", bus.cfg_done, 1'b1);
        commit_expect("cshift_final", 4'b1110, 4'b0000, 1'b0, 1'b0);

        // Reset mid-shift clears everything; a full fresh load is needed afterwards.
        bus.data_in = pick(0, 0, 0, 0);
        shift_word(16'hFFFF, 8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_data_out", bus.data_out, 4'b1111);
        check("mid_rst_range_err", bus.range_err, 4'b0000);
        check("mid_rst_cfg_out", bus.cfg_out, 1'b0);
        check("mid_rst_done", bus.cfg_done, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("mid_rst_commit_err", bus.cfg_err, 1'b1);
        shift_word(16'hFFFF, 15);
        check("mid_rst_done_15", bus.cfg_done, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("mid_rst_done_16", bus.cfg_done, 1'b1);
        commit_expect("mid_rst_final", 4'b0000, 4'b1111, 1'b0, 1'b0);

        check("scoreboard_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
